// File: rtl/ca_code_acq_if.sv
// Control and result bundle between the acquisition controller / chip sampler
// and the C/A serial-search acquisition engine.
interface ca_code_acq_if;
  logic       start;
  logic [5:0] prn_select;
  logic [9:0] threshold;
  logic       chip_valid;
  logic       chip_in;
  logic       busy;
  logic       done;
  logic       locked;
  logic [9:0] code_phase;
  logic [9:0] peak_mag;

  modport master (
    output start, prn_select, threshold, chip_valid, chip_in,
    input  busy, done, locked, code_phase, peak_mag
  );

  modport slave (
    input  start, prn_select, threshold, chip_valid, chip_in,
    output busy, done, locked, code_phase, peak_mag
  );
endinterface

// File: rtl/ca_code_acq.sv
// Serial-search GPS L1 C/A code acquisition: correlates a 1-bit chip stream
// against a local Gold-code replica, slipping the replica one chip per dwell.
module ca_code_acq #(
  parameter int MAX_TRIALS = 1023
) (
  input logic          clk,
  input logic          rst,
  ca_code_acq_if.slave acq
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DWELL = 2'd1;
  localparam logic [1:0] ST_SLIP  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [9:0] LAST_CHIP  = 10'd1022;
  localparam logic [9:0] LAST_TRIAL = 10'(MAX_TRIALS - 1);

  logic [1:0]  state;
  logic [9:0]  g1;
  logic [9:0]  g2;
  logic [9:0]  chip_idx;
  logic [9:0]  tap_mask;
  logic [9:0]  thresh_q;
  logic [10:0] agree;
  logic [9:0]  trial;
  logic [9:0]  best_mag;
  logic [9:0]  best_trial;
  logic        res_locked;
  logic [9:0]  res_phase;
  logic [9:0]  res_mag;
  logic        busy_q;
  logic        done_q;
  logic        locked_q;
  logic [9:0]  phase_q;
  logic [9:0]  mag_q;

  logic        start_ok;
  logic        prn_ok;
  logic        replica_bit;
  logic [10:0] agree_next;
  logic [9:0]  metric;
  logic        hit;
  logic        better;
  logic        last_trial;

  // G2 tap pair {a, b} per PRN; register stage k lives at bit k-1.
  function automatic logic [7:0] prn_taps(input logic [5:0] prn);
    case (prn)
      6'd1:    prn_taps = {4'd2, 4'd6};
      6'd2:    prn_taps = {4'd3, 4'd7};
      6'd3:    prn_taps = {4'd4, 4'd8};
      6'd4:    prn_taps = {4'd5, 4'd9};
      6'd5:    prn_taps = {4'd1, 4'd9};
      6'd6:    prn_taps = {4'd2, 4'd10};
      6'd7:    prn_taps = {4'd1, 4'd8};
      6'd8:    prn_taps = {4'd2, 4'd9};
      6'd9:    prn_taps = {4'd3, 4'd10};
      6'd10:   prn_taps = {4'd2, 4'd3};
      6'd11:   prn_taps = {4'd3, 4'd4};
      6'd12:   prn_taps = {4'd5, 4'd6};
      6'd13:   prn_taps = {4'd6, 4'd7};
      6'd14:   prn_taps = {4'd7, 4'd8};
      6'd15:   prn_taps = {4'd8, 4'd9};
      6'd16:   prn_taps = {4'd9, 4'd10};
      6'd17:   prn_taps = {4'd1, 4'd4};
      6'd18:   prn_taps = {4'd2, 4'd5};
      6'd19:   prn_taps = {4'd3, 4'd6};
      6'd20:   prn_taps = {4'd4, 4'd7};
      6'd21:   prn_taps = {4'd5, 4'd8};
      6'd22:   prn_taps = {4'd6, 4'd9};
      6'd23:   prn_taps = {4'd1, 4'd3};
      6'd24:   prn_taps = {4'd4, 4'd6};
      6'd25:   prn_taps = {4'd5, 4'd7};
      6'd26:   prn_taps = {4'd6, 4'd8};
      6'd27:   prn_taps = {4'd7, 4'd9};
      6'd28:   prn_taps = {4'd8, 4'd10};
      6'd29:   prn_taps = {4'd1, 4'd6};
      6'd30:   prn_taps = {4'd2, 4'd7};
      6'd31:   prn_taps = {4'd3, 4'd8};
      6'd32:   prn_taps = {4'd4, 4'd9};
      default: prn_taps = {4'd1, 4'd1};
    endcase
  endfunction

  function automatic logic [9:0] taps_to_mask(input logic [7:0] taps);
    taps_to_mask = (10'd1 << (taps[7:4] - 4'd1)) | (10'd1 << (taps[3:0] - 4'd1));
  endfunction

  function automatic logic [9:0] trial_to_phase(input logic [9:0] p);
    trial_to_phase = (p == 10'd0) ? 10'd0 : 10'd1023 - p;
  endfunction

  // Metric max(A, 1023-A): below 512 the complement equals the bitwise inverse.
  always_comb begin
    start_ok    = (state == ST_IDLE) && acq.start;
    prn_ok      = (acq.prn_select != 6'd0) && (acq.prn_select <= 6'd32);
    replica_bit = g1[9] ^ (^(g2 & tap_mask));
    agree_next  = agree + {10'd0, ~(acq.chip_in ^ replica_bit)};
    metric      = (agree_next >= 11'd512) ? agree_next[9:0] : ~agree_next[9:0];
    hit         = metric >= thresh_q;
    better      = metric > best_mag;
    last_trial  = trial == LAST_TRIAL;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      g1       <= '1;
      g2       <= '1;
      chip_idx <= '0;
    end else if (start_ok) begin
      g1       <= '1;
      g2       <= '1;
      chip_idx <= '0;
    end else if ((state == ST_DWELL) && acq.chip_valid) begin
      if (chip_idx == LAST_CHIP) begin
        g1       <= '1;
        g2       <= '1;
        chip_idx <= '0;
      end else begin
        g1       <= {g1[8:0], g1[2] ^ g1[9]};
        g2       <= {g2[8:0], g2[1] ^ g2[2] ^ g2[5] ^ g2[7] ^ g2[8] ^ g2[9]};
        chip_idx <= chip_idx + 10'd1;
      end
    end
  end

  // Search sequencing; results are staged in res_* and published from DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      tap_mask   <= '0;
      thresh_q   <= '0;
      agree      <= '0;
      trial      <= '0;
      best_mag   <= '0;
      best_trial <= '0;
      res_locked <= 1'b0;
      res_phase  <= '0;
      res_mag    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (acq.start) begin
            if (prn_ok) begin
              tap_mask   <= taps_to_mask(prn_taps(acq.prn_select));
              thresh_q   <= acq.threshold;
              agree      <= '0;
              trial      <= '0;
              best_mag   <= '0;
              best_trial <= '0;
              state      <= ST_DWELL;
            end else begin
              res_locked <= 1'b0;
              res_phase  <= '0;
              res_mag    <= '0;
              state      <= ST_DONE;
            end
          end
        end
        ST_DWELL: begin
          if (acq.chip_valid) begin
            agree <= agree_next;
            if (chip_idx == LAST_CHIP) begin
              if (hit) begin
                res_locked <= 1'b1;
                res_phase  <= trial_to_phase(trial);
                res_mag    <= metric;
                state      <= ST_DONE;
              end else begin
                if (better) begin
                  best_mag   <= metric;
                  best_trial <= trial;
                end
                if (last_trial) begin
                  res_locked <= 1'b0;
                  res_phase  <= trial_to_phase(better ? trial : best_trial);
                  res_mag    <= better ? metric : best_mag;
                  state      <= ST_DONE;
                end else begin
                  state <= ST_SLIP;
                end
              end
            end
          end
        end
        ST_SLIP: begin
          if (acq.chip_valid) begin
            trial <= trial + 10'd1;
            agree <= '0;
            state <= ST_DWELL;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      locked_q <= 1'b0;
      phase_q  <= '0;
      mag_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (start_ok) begin
        locked_q <= 1'b0;
        busy_q   <= prn_ok;
      end else if (state == ST_DONE) begin
        busy_q   <= 1'b0;
        done_q   <= 1'b1;
        locked_q <= res_locked;
        phase_q  <= res_phase;
        mag_q    <= res_mag;
      end
    end
  end

  assign acq.busy       = busy_q;
  assign acq.done       = done_q;
  assign acq.locked     = locked_q;
  assign acq.code_phase = phase_q;
  assign acq.peak_mag   = mag_q;

endmodule

// File: tb/tb_ca_code_acq.sv
// Bench for ca_code_acq: a sequence-level Gold-code and correlation model
// predicts every output cycle by cycle while directed streams are applied.
module tb_ca_code_acq;
  localparam int TB_TRIALS = 8;
  localparam int CODE_LEN  = 1023;
  localparam int SLOT      = CODE_LEN + 1;

  logic clk;
  logic rst;
  ca_code_acq_if acq ();

  ca_code_acq #(.MAX_TRIALS(TB_TRIALS)) dut (
    .clk (clk),
    .rst (rst),
    .acq (acq)
  );

  int checks   = 0;
  int failures = 0;
  bit check_en = 1'b0;
  bit exp_busy;
  bit exp_done;
  bit exp_locked;
  int exp_phase;
  int exp_mag;

  int tap_a [33] = '{0, 2, 3, 4, 5, 1, 2, 1, 2, 3, 2, 3, 5, 6, 7, 8, 9,
                     1, 2, 3, 4, 5, 6, 1, 4, 5, 6, 7, 8, 1, 2, 3, 4};
  int tap_b [33] = '{0, 6, 7, 8, 9, 9, 10, 8, 9, 10, 3, 4, 6, 7, 8, 9, 10,
                     4, 5, 6, 7, 8, 9, 3, 6, 7, 8, 9, 10, 6, 7, 8, 9};
  bit code_tab [33][CODE_LEN];
  bit stream [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at %0t: got %0d, want %0d", name, $time, actual, expected);
    end
  endtask

  // Codes from the stage-1 bit sequences of both LFSRs (all-ones history).
  task automatic build_code_table();
    bit x [CODE_LEN + 10];
    bit y [CODE_LEN + 10];
    for (int m = 0; m < 10; m++) begin
      x[m] = 1'b1;
      y[m] = 1'b1;
    end
    for (int m = 10; m < CODE_LEN + 10; m++) begin
      x[m] = x[m-3] ^ x[m-10];
      y[m] = y[m-2] ^ y[m-3] ^ y[m-6] ^ y[m-8] ^ y[m-9] ^ y[m-10];
    end
    for (int prn = 1; prn <= 32; prn++)
      for (int n = 0; n < CODE_LEN; n++)
        code_tab[prn][n] = x[n] ^ y[n + 10 - tap_a[prn]] ^ y[n + 10 - tap_b[prn]];
  endtask

  task automatic build_stream(input int prn, input int offset, input bit invert);
    stream.delete();
    for (int i = 0; i < TB_TRIALS * SLOT; i++)
      stream.push_back(code_tab[prn][(offset + i) % CODE_LEN] ^ invert);
  endtask

  // Trial p correlates stream chips [p*1024, p*1024+1022] with replica 0..1022.
  task automatic model_acq(input int prn, input int thr, output bit lk, output int ph,
                           output int mg, output int needed);
    int best;
    int best_p;
    int a;
    int m;
    best = 0; best_p = 0; lk = 1'b0; ph = 0; mg = 0; needed = 0;
    for (int p = 0; p < TB_TRIALS; p++) begin
      a = 0;
      for (int k = 0; k < CODE_LEN; k++)
        if (stream[p * SLOT + k] == code_tab[prn][k]) a++;
      m = (a > CODE_LEN - a) ? a : CODE_LEN - a;
      needed = p * SLOT + CODE_LEN;
      if (m >= thr) begin
        lk = 1'b1;
        ph = (CODE_LEN - p) % CODE_LEN;
        mg = m;
        return;
      end
      if (m > best) begin
        best   = m;
        best_p = p;
      end
    end
    ph = (CODE_LEN - best_p) % CODE_LEN;
    mg = best;
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      check_output("busy", acq.busy, exp_busy);
      check_output("done", acq.done, exp_done);
      check_output("locked", acq.locked, exp_locked);
      check_output("code_phase", acq.code_phase, exp_phase);
      check_output("peak_mag", acq.peak_mag, exp_mag);
    end
  end

  task automatic apply_stimulus(input int prn, input int thr, input int valid_period,
                                input int abort_chip, input bit mid_start);
    bit m_locked;
    int m_phase;
    int m_mag;
    int needed;
    int consumed;
    int cyc;
    bit good;
    good = (prn >= 1) && (prn <= 32);
    m_locked = 1'b0; m_phase = 0; m_mag = 0; needed = 0;
    if (good) model_acq(prn, thr, m_locked, m_phase, m_mag, needed);

    acq.start      = 1'b1;
    acq.prn_select = 6'(prn);
    acq.threshold  = 10'(thr);
    acq.chip_valid = 1'b1;
    acq.chip_in    = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    acq.start  = 1'b0;
    exp_locked = 1'b0;
    exp_busy   = good;

    consumed = 0;
    cyc      = 0;
    while (consumed < needed) begin
      acq.chip_valid = (cyc % valid_period) == 0;
      acq.chip_in    = acq.chip_valid ? stream[consumed] : 1'($urandom_range(0, 1));
      acq.start      = mid_start && (cyc == 500);
      if (mid_start) acq.prn_select = 6'd0;
      @(posedge clk); #1;
      if (acq.chip_valid) consumed++;
      cyc++;
      if ((abort_chip > 0) && (consumed == abort_chip)) begin
        rst            = 1'b0;
        acq.start      = 1'b0;
        acq.chip_valid = 1'b0;
        exp_busy = 1'b0; exp_done = 1'b0; exp_locked = 1'b0; exp_phase = 0; exp_mag = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        return;
      end
    end

    acq.start      = 1'b0;
    acq.chip_valid = 1'b1;
    acq.chip_in    = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
    exp_busy   = 1'b0;
    exp_done   = 1'b1;
    exp_locked = m_locked;
    exp_phase  = m_phase;
    exp_mag    = m_mag;
    @(posedge clk); #1;
    exp_done       = 1'b0;
    acq.chip_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    bit lk;
    int ph;
    int mg;
    int nd;
    int v;
    acq.start = 1'b0; acq.prn_select = '0; acq.threshold = '0;
    acq.chip_valid = 1'b0; acq.chip_in = 1'b0;
    exp_busy = 1'b0; exp_done = 1'b0; exp_locked = 1'b0; exp_phase = 0; exp_mag = 0;
    rst      = 1'b0;
    check_en = 1'b1;
    build_code_table();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;

    // First ten chips: PRN 1 = octal 1440, PRN 7 = octal 1131.
    v = 0;
    for (int n = 0; n < 10; n++) v = v * 2 + int'(code_tab[1][n]);
    check_output("model_prn1_head", v, 800);
    v = 0;
    for (int n = 0; n < 10; n++) v = v * 2 + int'(code_tab[7][n]);
    check_output("model_prn7_head", v, 601);

    $display("[TB] PRN 1 stream at index 1020, continuous");
    build_stream(1, 1020, 1'b0);
    model_acq(1, 1000, lk, ph, mg, nd);
    check_output("model_off_locked", lk, 1);
    check_output("model_off_phase", ph, 1020);
    check_output("model_off_mag", mg, 1023);
    check_output("model_off_chips", nd, 3 * SLOT + CODE_LEN);
    apply_stimulus(1, 1000, 1, 0, 1'b0);

    $display("[TB] inverted PRN 1 stream");
    build_stream(1, 1020, 1'b1);
    model_acq(1, 1000, lk, ph, mg, nd);
    check_output("model_inv_mag", mg, 1023);
    apply_stimulus(1, 1000, 1, 0, 1'b0);

    $display("[TB] prn_select 0");
    apply_stimulus(0, 500, 1, 0, 1'b0);

    $display("[TB] PRN 7 stream searched as PRN 3");
    build_stream(7, 0, 1'b0);
    model_acq(3, 900, lk, ph, mg, nd);
    check_output("model_xcorr_locked", lk, 0);
    check_output("model_xcorr_bound", mg <= 544, 1);
    check_output("model_xcorr_chips", nd, (TB_TRIALS - 1) * SLOT + CODE_LEN);
    apply_stimulus(3, 900, 1, 0, 1'b0);

    $display("[TB] prn_select 33");
    apply_stimulus(33, 500, 1, 0, 1'b0);

    $display("[TB] aligned PRN 1, chip_valid 1-of-3, stray start");
    build_stream(1, 0, 1'b0);
    model_acq(1, 1000, lk, ph, mg, nd);
    check_output("model_aligned_phase", ph, 0);
    check_output("model_aligned_chips", nd, CODE_LEN);
    apply_stimulus(1, 1000, 3, 0, 1'b1);

    $display("[TB] reset during trial 3, then reacquire");
    build_stream(1, 1020, 1'b0);
    apply_stimulus(1, 1000, 1, 3 * SLOT + 50, 1'b0);
    apply_stimulus(1, 1000, 1, 0, 1'b0);

    check_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
